// File: rtl/tx_buf_pkg.sv
// Shared defaults and helpers for the UART transmit data buffer.
// AW is derived here so every file sizes pointers the same way.
package tx_buf_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int DEPTH_DEF   = 16;

    // Ceiling log2; exact for the power-of-two depths this buffer accepts.
    function automatic int f_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_buf_ram.sv
// DEPTH x D_WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointer logic.
module tx_buf_ram
    import tx_buf_pkg::*;
#(
    parameter int  D_WIDTH = D_WIDTH_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int AW      = f_log2(DEPTH)
)(
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [D_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [D_WIDTH-1:0] o_rd_data
);

    logic [D_WIDTH-1:0] r_mem [DEPTH];

    // Storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/tx_data_buffer.sv
// FIFO between the host write strobe and the UART TX FSM, with a sticky overflow flag.
// All outputs are registered; o_data is preloaded with the next head word each edge.
module tx_data_buffer
    import tx_buf_pkg::*;
#(
    parameter int  D_WIDTH = D_WIDTH_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int AW      = f_log2(DEPTH)
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [D_WIDTH-1:0] i_data,
    output logic               o_full,
    output logic [D_WIDTH-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [AW:0]        o_count,
    output logic               o_ovf,
    input  logic               i_clr_ovf
);

    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_valid;
    logic               r_full;
    logic               r_ovf;
    logic [D_WIDTH-1:0] r_data;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_we;
    logic               w_bypass;
    logic [AW-1:0]      w_wr_ptr_nxt;
    logic [AW-1:0]      w_rd_ptr_nxt;
    logic [AW:0]        w_count_nxt;
    logic [D_WIDTH-1:0] w_ram_rdata;
    logic [D_WIDTH-1:0] w_data_nxt;

    assign w_pop  = r_valid & i_ready;
    assign w_push = i_enable & (~r_full | w_pop);
    assign w_drop = i_enable & r_full & ~w_pop;
    // Reset outranks a push, so the array is not written while reset is asserted
    assign w_we   = w_push & i_rst;

    tx_buf_ram #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_we      (w_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_ram_rdata)
    );

    // Next pointer and occupancy values
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Next head word; the incoming word becomes head when the queue would otherwise be empty
    always_comb begin
        w_bypass   = w_push & ((r_count == CNT_ZERO) | ((r_count == CNT_ONE) & w_pop));
        w_data_nxt = '0;
        if (w_count_nxt == CNT_ZERO) begin
            w_data_nxt = '0;
        end else if (w_bypass) begin
            w_data_nxt = i_data;
        end else begin
            w_data_nxt = w_ram_rdata;
        end
    end

    // Pointer, occupancy and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != CNT_ZERO);
            r_full   <= (w_count_nxt == CNT_FULL);
            r_data   <= w_data_nxt;
        end
    end

    // Sticky overflow: a dropped word outranks a clear in the same cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign o_full  = r_full;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the data word width in bits; legal range 1..32.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of storage entries; it SHALL be a power of two in 2..256.
REQ-003 The block SHALL derive the constant AW = log2(DEPTH) internally; AW SHALL NOT be overridable.
REQ-004 i_clk  input  1  clock; all state changes on the rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-low.
REQ-006 i_enable  input  1  write strobe; requests a load of i_data this cycle.
REQ-007 i_data  input  D_WIDTH  write data.
REQ-008 o_full  output  1  buffer holds DEPTH words.
REQ-009 o_data  output  D_WIDTH  head-of-queue word for the UART TX FSM.
REQ-010 o_valid  output  1  o_data holds a valid word.
REQ-011 i_ready  input  1  TX FSM accepts the head word this cycle.
REQ-012 o_count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 o_ovf  output  1  sticky overflow flag.
REQ-014 i_clr_ovf  input  1  clears o_ovf.

Function
REQ-015 pop SHALL be defined as o_valid & i_ready; push SHALL be defined as i_enable & (~o_full | pop).
REQ-016 Words SHALL leave the buffer in strict first-in, first-out order.
REQ-017 o_valid SHALL equal (count != 0), and o_full SHALL equal (count == DEPTH).
REQ-018 o_data SHALL equal the head entry when o_valid=1 and SHALL be 0 when o_valid=0.
REQ-019 Latency: a word pushed into an empty buffer in cycle N SHALL appear on o_data with o_valid=1 in cycle N+1; there SHALL be no same-cycle bypass.
REQ-020 While o_valid=1 and i_ready=0, o_data and o_valid SHALL stay stable.
REQ-021 When the buffer is empty, i_ready SHALL be ignored; the pointers and count SHALL NOT change.
REQ-022 On push with no pop, count SHALL increment by 1 on the next edge; on pop with no push, count SHALL decrement by 1.
REQ-023 On push and pop in the same cycle, including when full, both SHALL take effect and count SHALL be unchanged.
REQ-024 When full with no pop, i_enable=1 SHALL drop the word: storage and count SHALL be unchanged and o_ovf SHALL be 1 from the next cycle.
REQ-025 o_ovf SHALL remain 1 until i_clr_ovf=1; if a new overflow and i_clr_ovf occur in the same cycle, the set SHALL win.
REQ-026 The read and write pointers SHALL wrap modulo DEPTH with no gap or duplicated entry.

Reset
REQ-027 With i_rst=0 at a rising edge, the block SHALL drive count=0, both pointers=0, o_valid=0, o_full=0, o_ovf=0 and o_data=0; storage contents SHALL NOT be reset.
REQ-028 Reset SHALL take priority over push, pop and i_clr_ovf in the same cycle.
REQ-029 A reset mid-operation SHALL discard all queued words; the first push after release SHALL be the first word out.

Structure
REQ-030 Package tx_buf_pkg SHALL hold the D_WIDTH and DEPTH defaults and the log2 helper used to derive AW.
REQ-031 Storage SHALL be a sub-module tx_buf_ram: a DEPTH x D_WIDTH register array with one synchronous write port and one asynchronous read port.
REQ-032 The pointers, count, overflow flag and handshake logic SHALL reside in tx_data_buffer.

Verification
REQ-033 Reset, then push 0xA5 with i_ready=0 -> next cycle o_valid=1, o_data=0xA5, o_count=1; these values hold for 5 stall cycles.
REQ-034 Push 0x00..0x0F with i_ready=0 -> o_full=1 and o_count=16; then i_ready=1 -> outputs 0x00..0x0F in order, and o_valid=0 after the 16th pop.
REQ-035 Full buffer, push 0xFF with i_ready=0 -> o_ovf=1 and o_count=16, and the drained sequence excludes 0xFF; an i_clr_ovf pulse -> o_ovf=0.
REQ-036 Full buffer, push 0x55 with i_ready=1 in the same cycle -> o_count stays 16 and 0x55 is the last word out.
REQ-037 o_count=5, i_rst=0 for one cycle with i_enable=1 -> o_count=0, o_valid=0, o_ovf=0; a subsequent push of 0x3C is the first word out.
REQ-038 D_WIDTH=12, DEPTH=4: three fill/drain rounds of 0xABC, 0x123, 0xFFF, 0x001 -> pointers wrap and every word is output intact and in order.
